// File: rtl/mmio_led_btn.sv
// Memory-mapped LED register and debounced push-button status responder for the I/O bus window.
// Optional sticky button-rise latch at 0x4008 enabled by defining MMIO_BTN_EDGE_LATCH_EN.
module mmio_led_btn #(
    parameter int unsigned NUM_LEDS        = 16,
    parameter int unsigned NUM_BTNS        = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter logic [31:0] LED_ADDR        = 32'h0000_4000,
    parameter logic [31:0] BTN_ADDR        = 32'h0000_4004
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         addr_in,
    input  logic                wr_en,
    input  logic [31:0]         wr_data,
    input  logic                rd_en,
    output logic [31:0]         rd_data,
    output logic                rd_valid,
    input  logic [NUM_BTNS-1:0] btns_in,
    output logic [NUM_LEDS-1:0] leds_out
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_LEDS-1:0] led_reg;
    logic [NUM_BTNS-1:0] sync1;
    logic [NUM_BTNS-1:0] sync2;
    logic [NUM_BTNS-1:0] btn_stable;
    logic [NUM_BTNS-1:0] btn_stable_nxt;
    logic [CNT_W-1:0]    cnt     [NUM_BTNS];
    logic [CNT_W-1:0]    cnt_nxt [NUM_BTNS];
    logic [31:0]         rd_mux_c;
    logic                led_wr_c;
    logic                unused_wr_bits;

    // Upper store-data bits beyond the LED width are intentionally dropped.
    assign unused_wr_bits = ^wr_data;

    assign led_wr_c = wr_en && (addr_in == LED_ADDR);
    assign leds_out = led_reg;

    // Per-button debounce: any disagreement must persist DEBOUNCE_CYCLES cycles.
    always_comb begin
        btn_stable_nxt = btn_stable;
        for (int i = 0; i < int'(NUM_BTNS); i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != btn_stable[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    btn_stable_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef MMIO_BTN_EDGE_LATCH_EN
    localparam logic [31:0] EDGE_ADDR = 32'h0000_4008;

    logic [NUM_BTNS-1:0] btn_edge;
    logic [NUM_BTNS-1:0] btn_rise_c;
    logic [NUM_BTNS-1:0] edge_clr_c;

    assign btn_rise_c = btn_stable_nxt & ~btn_stable;
    assign edge_clr_c = (wr_en && (addr_in == EDGE_ADDR)) ? wr_data[NUM_BTNS-1:0] : '0;

    // A rise coinciding with a clear keeps the bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_edge <= '0;
        end else begin
            btn_edge <= (btn_edge & ~edge_clr_c) | btn_rise_c;
        end
    end
`endif

    always_comb begin
        rd_mux_c = 32'h0;
        if (addr_in == LED_ADDR) begin
            rd_mux_c = 32'(led_reg);
        end else if (addr_in == BTN_ADDR) begin
            rd_mux_c = 32'(btn_stable);
`ifdef MMIO_BTN_EDGE_LATCH_EN
        end else if (addr_in == EDGE_ADDR) begin
            rd_mux_c = 32'(btn_edge);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_reg    <= '0;
            rd_data    <= 32'h0;
            rd_valid   <= 1'b0;
            sync1      <= '0;
            sync2      <= '0;
            btn_stable <= '0;
            for (int i = 0; i < int'(NUM_BTNS); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            if (led_wr_c) begin
                led_reg <= wr_data[NUM_LEDS-1:0];
            end
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_mux_c;
            end
            sync1      <= btns_in;
            sync2      <= sync1;
            btn_stable <= btn_stable_nxt;
            for (int i = 0; i < int'(NUM_BTNS); i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_mmio_led_btn.sv
// Scoreboard bench for mmio_led_btn with a short debounce window.
module tb_mmio_led_btn;

    localparam int unsigned NUM_LEDS = 16;
    localparam int unsigned NUM_BTNS = 5;
    localparam int unsigned DEB      = 4;
    localparam logic [31:0] LED_A    = 32'h0000_4000;
    localparam logic [31:0] BTN_A    = 32'h0000_4004;
    localparam logic [31:0] EDGE_A   = 32'h0000_4008;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [31:0]         addr_in = 32'h0;
    logic                wr_en = 1'b0;
    logic [31:0]         wr_data = 32'h0;
    logic                rd_en = 1'b0;
    logic [31:0]         rd_data;
    logic                rd_valid;
    logic [NUM_BTNS-1:0] btns_in = '0;
    logic [NUM_LEDS-1:0] leds_out;

    int tests  = 0;
    int failed = 0;
    logic [31:0] exp_q[$];

    mmio_led_btn #(
        .NUM_LEDS(NUM_LEDS), .NUM_BTNS(NUM_BTNS), .DEBOUNCE_CYCLES(DEB),
        .LED_ADDR(LED_A), .BTN_ADDR(BTN_A)
    ) dut (
        .clk(clk), .rst(rst), .addr_in(addr_in), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .btns_in(btns_in), .leds_out(leds_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Outputs sampled on the falling edge; each valid pops one expected read.
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (exp_q.size() == 0) check("unexpected_valid", 32'(rd_valid), 32'h0);
            else check("rd_data", rd_data, exp_q.pop_front());
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        addr_in = a; wr_data = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp);
        addr_in = a; rd_en = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_leds", 32'(leds_out), 32'h0);
        check("reset_rd_valid", 32'(rd_valid), 32'h0);
        check("reset_rd_data", rd_data, 32'h0);
        rst = 1'b0;
        do_read(BTN_A, 32'h0);

        // LED write then read back
        do_write(LED_A, 32'hDEAD_BEEF);
        check("led_write", 32'(leds_out), 32'h0000_BEEF);
        do_read(LED_A, 32'h0000_BEEF);

        // Simultaneous read/write returns the old value
        do_write(LED_A, 32'h0000_00AA);
        addr_in = LED_A; wr_data = 32'h0000_0055; wr_en = 1'b1; rd_en = 1'b1;
        exp_q.push_back(32'h0000_00AA);
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        check("led_after_rw", 32'(leds_out), 32'h0000_0055);

        // Unmapped / misaligned writes leave the LEDs alone
        do_write(32'h0000_4002, 32'h0000_1234);
        do_write(32'h0000_0000, 32'h0000_5678);
        check("led_unmapped_wr", 32'(leds_out), 32'h0000_0055);

        // 3-cycle glitch never reaches btn_stable; reads run back to back
        btns_in[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (k == 4) btns_in[0] = 1'b0;
            addr_in = BTN_A; rd_en = 1'b1;
            exp_q.push_back(32'h0);
            @(negedge clk);
        end
        rd_en = 1'b0;
        repeat (3) @(negedge clk);

        // Held press: stable rises at the 6th edge, first visible to the read at edge 7
        btns_in[0] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            addr_in = BTN_A; rd_en = 1'b1;
            exp_q.push_back((k >= 7) ? 32'h1 : 32'h0);
            @(negedge clk);
        end
        rd_en = 1'b0;

        // Unmapped reads and read-only button word
        do_read(32'h0000_4001, 32'h0);
        do_read(32'h0000_5000, 32'h0);
        do_write(BTN_A, 32'hFFFF_FFFF);
        do_read(BTN_A, 32'h1);
        do_read(LED_A, 32'h0000_0055);

`ifdef MMIO_BTN_EDGE_LATCH_EN
        do_read(EDGE_A, 32'h1);
        do_write(EDGE_A, 32'hFFFF_FFFF);
        do_read(EDGE_A, 32'h0);
        btns_in[2] = 1'b1;
        repeat (10) @(negedge clk);
        do_read(EDGE_A, 32'h4);
        do_write(EDGE_A, 32'h4);
        do_read(EDGE_A, 32'h0);
        // Clear lands on the same edge as btn 3's debounced rise
        btns_in[3] = 1'b1;
        repeat (5) @(negedge clk);
        do_write(EDGE_A, 32'h8);
        do_read(EDGE_A, 32'h8);
        do_read(BTN_A, 32'hD);
`else
        do_write(EDGE_A, 32'hFFFF_FFFF);
        do_read(EDGE_A, 32'h0);
        check("led_edge_wr", 32'(leds_out), 32'h0000_0055);
`endif

        // Debounced release
        btns_in = '0;
        repeat (10) @(negedge clk);
        do_read(BTN_A, 32'h0);

        repeat (4) @(negedge clk);
        check("scoreboard_drain", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
